// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants: datapath widths, forwarding selects,
// and the MEM/WB control bundle carried through the EX/MEM register.
package pipe_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    // An invalid instruction must travel as a bubble: all control bits cleared.
    function automatic mem_ctrl_t gate_ctrl(input mem_ctrl_t c, input logic en);
        mem_ctrl_t g;
        g.reg_write  = c.reg_write  & en;
        g.mem_read   = c.mem_read   & en;
        g.mem_write  = c.mem_write  & en;
        g.mem_to_reg = c.mem_to_reg & en;
        return g;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side payload and hazard inputs in, registered MEM-side
// payload, forwarding selects and overflow-trap status out.
interface ex_mem_stage_if;
    import pipe_pkg::*;

    logic          stall;
    logic          flush;

    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_result;
    logic          ex_ovf;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;

    logic [RW-1:0] idex_rs;
    logic [RW-1:0] idex_rt;
    logic [RW-1:0] wb_rd;
    logic          wb_reg_write;

    logic          mem_valid;
    logic [DW-1:0] mem_pc;
    logic [DW-1:0] mem_result;
    logic [DW-1:0] mem_store_data;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_write;
    logic          mem_mem_read;
    logic          mem_mem_write;
    logic          mem_mem_to_reg;

    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;

    logic          ovf_pulse;
    logic          ovf_sticky;
    logic [DW-1:0] epc;

    modport master (
        output stall, flush,
        output ex_valid, ex_pc, ex_result, ex_ovf, ex_store_data, ex_rd,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
        output idex_rs, idex_rt, wb_rd, wb_reg_write,
        input  mem_valid, mem_pc, mem_result, mem_store_data, mem_rd,
        input  mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
        input  fwd_a_sel, fwd_b_sel,
        input  ovf_pulse, ovf_sticky, epc
    );

    modport slave (
        input  stall, flush,
        input  ex_valid, ex_pc, ex_result, ex_ovf, ex_store_data, ex_rd,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
        input  idex_rs, idex_rt, wb_rd, wb_reg_write,
        output mem_valid, mem_pc, mem_result, mem_store_data, mem_rd,
        output mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
        output fwd_a_sel, fwd_b_sel,
        output ovf_pulse, ovf_sticky, epc
    );

endinterface

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding select; EX/MEM beats MEM/WB and $0
// is never a forwarding source.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_rd,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel
);

    function automatic logic [1:0] pick(input logic [RW-1:0] src,
                                        input logic          m_we,
                                        input logic [RW-1:0] m_rd,
                                        input logic          w_we,
                                        input logic [RW-1:0] w_rd);
        logic [1:0] sel;
        sel = FWD_RF;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = pick(rs, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
        fwd_b_sel = pick(rt, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with operand forwarding and overflow squash.
// Overflow trap (squash, pulse, sticky flag, EPC) enabled by EX_MEM_OVF_TRAP_EN.
module ex_mem_stage
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave bus
);

    logic          valid_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] result_q;
    logic [DW-1:0] store_data_q;
    logic [RW-1:0] rd_q;
    mem_ctrl_t     ctrl_q;

    mem_ctrl_t     ex_ctrl;
    mem_ctrl_t     ld_ctrl;
    logic          load_en;

    assign load_en = !bus.flush && !bus.stall;

`ifdef EX_MEM_OVF_TRAP_EN
    logic          ovf_hit;
    logic          pulse_q;
    logic          sticky_q;
    logic [DW-1:0] epc_q;

    assign ovf_hit = bus.ex_valid & bus.ex_ovf;
`else
    logic          unused_ovf;

    assign unused_ovf = bus.ex_ovf;
`endif

    // Control to be loaded: bubble when invalid, squashed on overflow.
    always_comb begin
        ex_ctrl.reg_write  = bus.ex_reg_write;
        ex_ctrl.mem_read   = bus.ex_mem_read;
        ex_ctrl.mem_write  = bus.ex_mem_write;
        ex_ctrl.mem_to_reg = bus.ex_mem_to_reg;
        ld_ctrl = gate_ctrl(ex_ctrl, bus.ex_valid);
`ifdef EX_MEM_OVF_TRAP_EN
        if (ovf_hit) begin
            ld_ctrl.reg_write = 1'b0;
            ld_ctrl.mem_read  = 1'b0;
            ld_ctrl.mem_write = 1'b0;
        end
`endif
    end

    // Stage register; flush only clears the fields that make it a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            result_q     <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            ctrl_q       <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (!bus.stall) begin
            valid_q      <= bus.ex_valid;
            pc_q         <= bus.ex_pc;
            result_q     <= bus.ex_result;
            store_data_q <= bus.ex_store_data;
            rd_q         <= bus.ex_rd;
            ctrl_q       <= ld_ctrl;
        end
    end

`ifdef EX_MEM_OVF_TRAP_EN
    // Trap status: pulse only on the loading edge, EPC latched on first overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            epc_q    <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (load_en && ovf_hit) begin
                pulse_q  <= 1'b1;
                sticky_q <= 1'b1;
                if (!sticky_q) begin
                    epc_q <= bus.ex_pc;
                end
            end
        end
    end

    assign bus.ovf_pulse  = pulse_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.epc        = epc_q;
`else
    logic unused_load_en;

    assign unused_load_en = load_en;
    assign bus.ovf_pulse  = 1'b0;
    assign bus.ovf_sticky = 1'b0;
    assign bus.epc        = '0;
`endif

    assign bus.mem_valid      = valid_q;
    assign bus.mem_pc         = pc_q;
    assign bus.mem_result     = result_q;
    assign bus.mem_store_data = store_data_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_reg_write  = ctrl_q.reg_write;
    assign bus.mem_mem_read   = ctrl_q.mem_read;
    assign bus.mem_mem_write  = ctrl_q.mem_write;
    assign bus.mem_mem_to_reg = ctrl_q.mem_to_reg;

    fwd_unit u_fwd (
        .mem_reg_write (ctrl_q.reg_write),
        .mem_rd        (rd_q),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .rs            (bus.idex_rs),
        .rt            (bus.idex_rt),
        .fwd_a_sel     (bus.fwd_a_sel),
        .fwd_b_sel     (bus.fwd_b_sel)
    );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed, table-driven bench for ex_mem_stage; overflow expectations follow
// whether EX_MEM_OVF_TRAP_EN is defined for the build.
module tb_ex_mem_stage;

`ifdef EX_MEM_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        rst, stall, flush, valid, ovf;
        logic [31:0] pc, result, sd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;   // {reg_write, mem_read, mem_write, mem_to_reg}
        logic [4:0]  rs, rt, wb_rd;
        logic        wb_rw;
    } vin_t;

    typedef struct {
        logic        chk_data;
        logic        valid;
        logic [31:0] pc, result, sd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic [1:0]  fa, fb;
        logic        pulse, sticky;
        logic [31:0] epc;
    } vexp_t;

    typedef struct {
        vin_t  i;
        vexp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vin_t vi(input logic r, input logic s, input logic f,
                                input logic v, input logic o,
                                input logic [31:0] pc, input logic [31:0] res,
                                input logic [31:0] sd, input logic [4:0] rd,
                                input logic [3:0] ctrl, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] wrd,
                                input logic wrw);
        vin_t x;
        x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.ovf = o;
        x.pc = pc; x.result = res; x.sd = sd; x.rd = rd; x.ctrl = ctrl;
        x.rs = rs; x.rt = rt; x.wb_rd = wrd; x.wb_rw = wrw;
        return x;
    endfunction

    function automatic vexp_t ve(input logic cd, input logic v,
                                 input logic [31:0] pc, input logic [31:0] res,
                                 input logic [31:0] sd, input logic [4:0] rd,
                                 input logic [3:0] ctrl, input logic [1:0] fa,
                                 input logic [1:0] fb, input logic p,
                                 input logic st, input logic [31:0] epc);
        vexp_t x;
        x.chk_data = cd; x.valid = v; x.pc = pc; x.result = res; x.sd = sd;
        x.rd = rd; x.ctrl = ctrl; x.fa = fa; x.fb = fb;
        x.pulse = p; x.sticky = st; x.epc = epc;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vin_t x);
        rst               = x.rst;
        bus.stall         = x.stall;
        bus.flush         = x.flush;
        bus.ex_valid      = x.valid;
        bus.ex_ovf        = x.ovf;
        bus.ex_pc         = x.pc;
        bus.ex_result     = x.result;
        bus.ex_store_data = x.sd;
        bus.ex_rd         = x.rd;
        {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg} = x.ctrl;
        bus.idex_rs       = x.rs;
        bus.idex_rt       = x.rt;
        bus.wb_rd         = x.wb_rd;
        bus.wb_reg_write  = x.wb_rw;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input vexp_t e);
        logic [3:0] ctrl;
        ctrl = {bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg};
        chk({tag, ".valid"}, 32'(bus.mem_valid), 32'(e.valid));
        chk({tag, ".ctrl"},  32'(ctrl),          32'(e.ctrl));
        chk({tag, ".rd"},    32'(bus.mem_rd),    32'(e.rd));
        if (e.chk_data) begin
            chk({tag, ".pc"},     bus.mem_pc,         e.pc);
            chk({tag, ".result"}, bus.mem_result,     e.result);
            chk({tag, ".sd"},     bus.mem_store_data, e.sd);
        end
        chk({tag, ".fwd_a"},  32'(bus.fwd_a_sel),  32'(e.fa));
        chk({tag, ".fwd_b"},  32'(bus.fwd_b_sel),  32'(e.fb));
        chk({tag, ".pulse"},  32'(bus.ovf_pulse),  32'(e.pulse));
        chk({tag, ".sticky"}, 32'(bus.ovf_sticky), 32'(e.sticky));
        chk({tag, ".epc"},    bus.epc,             e.epc);
    endtask

    vec_t tab[14];

    initial begin
        logic [31:0] e_epc;
        //             rst st fl v  o  pc      result        sd      rd  ctrl     rs  rt  wbrd wbrw
        tab[0]  = '{vi(1, 0, 0, 1, 1, 32'h4,  32'hFFFF,     32'h55, 3,  4'b1111, 3,  3,  0,  0),
                    ve(1, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 0)};
        tab[1]  = tab[0];
        tab[2]  = '{vi(0, 0, 0, 1, 0, 32'h10, 32'h1234,     32'h99, 8,  4'b1000, 8,  0,  8,  1),
                    ve(1, 1, 32'h10, 32'h1234, 32'h99, 8, 4'b1000, 2'b01, 2'b00, 0, 0, 0)};
        tab[3]  = '{vi(0, 1, 0, 1, 0, 32'h14, 32'h5555,     32'h0,  9,  4'b1100, 9,  8,  9,  1),
                    ve(1, 1, 32'h10, 32'h1234, 32'h99, 8, 4'b1000, 2'b10, 2'b01, 0, 0, 0)};
        tab[4]  = '{vi(0, 0, 0, 1, 0, 32'h18, 32'h77,       32'h0,  0,  4'b1001, 0,  0,  0,  1),
                    ve(1, 1, 32'h18, 32'h77, 32'h0, 0, 4'b1001, 2'b00, 2'b00, 0, 0, 0)};
        tab[5]  = '{vi(0, 0, 0, 0, 0, 32'h1C, 32'hDEAD,     32'h11, 5,  4'b1111, 5,  6,  6,  1),
                    ve(1, 0, 32'h1C, 32'hDEAD, 32'h11, 5, 4'b0000, 2'b00, 2'b10, 0, 0, 0)};
        tab[6]  = '{vi(0, 0, 0, 1, 0, 32'h20, 32'hAAAA0001, 32'h22, 10, 4'b1100, 10, 10, 10, 0),
                    ve(1, 1, 32'h20, 32'hAAAA0001, 32'h22, 10, 4'b1100, 2'b01, 2'b01, 0, 0, 0)};
        tab[7]  = '{vi(0, 1, 0, 1, 0, 32'h24, 32'hBBBB0002, 32'h33, 11, 4'b1000, 10, 11, 0,  0),
                    ve(1, 1, 32'h20, 32'hAAAA0001, 32'h22, 10, 4'b1100, 2'b01, 2'b00, 0, 0, 0)};
        tab[8]  = tab[7];
        tab[9]  = tab[7];
        tab[10] = '{vi(0, 1, 1, 1, 0, 32'h28, 32'hCCCC0003, 32'h44, 12, 4'b1111, 12, 0,  12, 1),
                    ve(0, 0, 0, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 0, 0, 0)};
        tab[11] = '{vi(0, 0, 1, 1, 0, 32'h2C, 32'hDDDD0004, 32'h55, 13, 4'b1111, 3,  3,  0,  0),
                    ve(0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 0)};
        tab[12] = '{vi(0, 0, 0, 1, 0, 32'h30, 32'h0F0F,     32'h3C, 31, 4'b1001, 31, 31, 31, 1),
                    ve(1, 1, 32'h30, 32'h0F0F, 32'h3C, 31, 4'b1001, 2'b01, 2'b01, 0, 0, 0)};
        tab[13] = '{vi(1, 0, 0, 1, 1, 32'h34, 32'h1,        32'h1,  1,  4'b1111, 1,  1,  0,  0),
                    ve(1, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 0)};

        for (int i = 0; i < 14; i++) begin
            apply(tab[i].i);
            check($sformatf("v%0d", i), tab[i].e);
        end

        // Overflow sequence, starting from the reset state left by the table.
        e_epc = TRAP ? 32'h40 : 32'h0;
        apply(vi(0, 0, 0, 1, 1, 32'h40, 32'h80000000, 32'h0, 4, 4'b1000, 4, 0, 0, 0));
        check("ovf1", ve(1, 1, 32'h40, 32'h80000000, 32'h0, 4, TRAP ? 4'b0000 : 4'b1000,
                         TRAP ? 2'b00 : 2'b01, 2'b00, TRAP, TRAP, e_epc));

        apply(vi(0, 0, 0, 1, 0, 32'h44, 32'h5, 32'h0, 2, 4'b1000, 2, 0, 0, 0));
        check("after_ovf", ve(1, 1, 32'h44, 32'h5, 32'h0, 2, 4'b1000, 2'b01, 2'b00, 0, TRAP, e_epc));

        apply(vi(0, 0, 0, 1, 1, 32'h80, 32'h80000001, 32'h66, 6, 4'b0111, 0, 6, 0, 0));
        check("ovf2", ve(1, 1, 32'h80, 32'h80000001, 32'h66, 6, TRAP ? 4'b0001 : 4'b0111,
                         2'b00, 2'b00, TRAP, TRAP, e_epc));

        apply(vi(0, 1, 0, 1, 1, 32'h90, 32'h80000002, 32'h77, 7, 4'b1000, 0, 0, 0, 0));
        check("ovf_stall", ve(1, 1, 32'h80, 32'h80000001, 32'h66, 6, TRAP ? 4'b0001 : 4'b0111,
                              2'b00, 2'b00, 0, TRAP, e_epc));

        apply(vi(0, 0, 1, 1, 1, 32'h94, 32'h80000003, 32'h0, 7, 4'b1000, 0, 0, 0, 0));
        check("ovf_flush", ve(0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, TRAP, e_epc));

        apply(vi(0, 0, 0, 0, 1, 32'hA0, 32'h80000004, 32'h0, 9, 4'b1000, 9, 0, 0, 0));
        check("ovf_invalid", ve(1, 0, 32'hA0, 32'h80000004, 32'h0, 9, 4'b0000,
                                2'b00, 2'b00, 0, TRAP, e_epc));

        apply(vi(1, 0, 0, 1, 1, 32'hB0, 32'h1, 32'h1, 1, 4'b1111, 0, 0, 0, 0));
        check("ovf_rst", ve(1, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
